fft_ctrl: RTL and testbench

FFT_CTRL -- requirements
Module: fft_ctrl

---
 rtl/fft_ctrl_if.sv | 37 +++
 rtl/fft_ctrl.sv | 135 +++++++++++++
 tb/tb_fft_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_ctrl_if.sv
// Handshake, frame buffer and stage-control bundle between the FFT controller and its datapath/consumer.
interface fft_ctrl_if;
    localparam int unsigned SAMPLE_W  = 12;
    localparam int unsigned FRAME_LEN = 8;
    localparam int unsigned IDX_W     = 3;

    logic                       in_valid;
    logic                       in_ready;
    logic signed [SAMPLE_W-1:0] in_sample;
    logic signed [SAMPLE_W-1:0] frame_data [0:FRAME_LEN-1];
    logic                       stage1_en;
    logic                       stage2_en;
    logic                       stage3_en;
    logic                       stage1_done;
    logic                       stage2_done;
    logic                       stage3_done;
    logic                       out_valid;
    logic                       out_ready;
    logic [IDX_W-1:0]           out_index;
    logic                       busy;
    logic                       frame_done;
    logic                       timeout_err;

    // Controller side
    modport slave (
        input  in_valid, in_sample, stage1_done, stage2_done, stage3_done, out_ready,
        output in_ready, frame_data, stage1_en, stage2_en, stage3_en,
               out_valid, out_index, busy, frame_done, timeout_err
    );

    // Environment side (sample source, stage datapaths, consumer)
    modport master (
        output in_valid, in_sample, stage1_done, stage2_done, stage3_done, out_ready,
        input  in_ready, frame_data, stage1_en, stage2_en, stage3_en,
               out_valid, out_index, busy, frame_done, timeout_err
    );
endinterface

// File: rtl/fft_ctrl.sv
// 8-point FFT sequencer: buffers a frame, steps three datapath stages with a watchdog,
// then walks the consumer through bins 0..7.
module fft_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input logic        CLK,
    input logic        nRESET,
    fft_ctrl_if.slave  bus
);
    localparam int unsigned SAMPLE_W  = 12;
    localparam int unsigned FRAME_LEN = 8;
    localparam int unsigned IDX_W     = 3;
    localparam int unsigned WD_W      = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, LOAD, S1, S2, S3, UNLOAD} state_t;

    state_t                     state_q, state_d;
    logic [IDX_W-1:0]           load_cnt_q, load_cnt_d;
    logic [IDX_W-1:0]           out_idx_q, out_idx_d;
    logic [WD_W-1:0]            wd_q, wd_d;
    logic signed [SAMPLE_W-1:0] frame_q [FRAME_LEN];
    logic signed [SAMPLE_W-1:0] frame_d [FRAME_LEN];
    logic in_ready_q, in_ready_d;
    logic out_valid_q, out_valid_d;
    logic st1_en_q, st1_en_d;
    logic st2_en_q, st2_en_d;
    logic st3_en_q, st3_en_d;
    logic busy_q, busy_d;
    logic frame_done_q, frame_done_d;
    logic timeout_err_q, timeout_err_d;
    logic stage_done_c;

    // Next-state, counters and frame buffer; every output flop is decoded from the next state
    always_comb begin
        state_d       = state_q;
        load_cnt_d    = load_cnt_q;
        out_idx_d     = out_idx_q;
        wd_d          = wd_q;
        frame_d       = frame_q;
        frame_done_d  = 1'b0;
        timeout_err_d = 1'b0;
        stage_done_c  = 1'b0;

        case (state_q)
            IDLE: state_d = LOAD;
            LOAD: begin
                if (bus.in_valid && in_ready_q) begin
                    frame_d[load_cnt_q] = bus.in_sample;
                    load_cnt_d          = load_cnt_q + 1'b1;
                    if (load_cnt_q == IDX_W'(FRAME_LEN - 1)) begin
                        load_cnt_d = '0;
                        state_d    = S1;
                    end
                end
            end
            S1, S2, S3: begin
                stage_done_c = ((state_q == S1) && bus.stage1_done) ||
                               ((state_q == S2) && bus.stage2_done) ||
                               ((state_q == S3) && bus.stage3_done);
                // The cycle that reports the abort is the last one spent in the stage
                if (wd_q == WD_W'(TIMEOUT)) begin
                    state_d    = LOAD;
                    load_cnt_d = '0;
                end else if (stage_done_c) begin
                    state_d = (state_q == S1) ? S2 : (state_q == S2) ? S3 : UNLOAD;
                end else begin
                    wd_d          = wd_q + 1'b1;
                    timeout_err_d = (wd_d == WD_W'(TIMEOUT));
                end
            end
            UNLOAD: begin
                if (out_valid_q && bus.out_ready) begin
                    out_idx_d = out_idx_q + 1'b1;
                    if (out_idx_q == IDX_W'(FRAME_LEN - 1)) begin
                        state_d      = LOAD;
                        frame_done_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) wd_d = '0;

        in_ready_d  = (state_d == LOAD);
        out_valid_d = (state_d == UNLOAD);
        st1_en_d    = (state_d == S1) && (state_q != S1);
        st2_en_d    = (state_d == S2) && (state_q != S2);
        st3_en_d    = (state_d == S3) && (state_q != S3);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            state_q       <= IDLE;
            load_cnt_q    <= '0;
            out_idx_q     <= '0;
            wd_q          <= '0;
            frame_q       <= '{default: '0};
            in_ready_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            st1_en_q      <= 1'b0;
            st2_en_q      <= 1'b0;
            st3_en_q      <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            load_cnt_q    <= load_cnt_d;
            out_idx_q     <= out_idx_d;
            wd_q          <= wd_d;
            frame_q       <= frame_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            st1_en_q      <= st1_en_d;
            st2_en_q      <= st2_en_d;
            st3_en_q      <= st3_en_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.frame_data  = frame_q;
    assign bus.stage1_en   = st1_en_q;
    assign bus.stage2_en   = st2_en_q;
    assign bus.stage3_en   = st3_en_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_index   = out_idx_q;
    assign bus.busy        = busy_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_fft_ctrl.sv
// Scoreboard bench for fft_ctrl: expected pulses/bins and signal probes are queued with their
// cycle numbers by the stimulus thread and checked by an independent negedge monitor.
module tb_fft_ctrl;
    localparam int unsigned TIMEOUT = 16;
    localparam int EV_EN1 = 1, EV_EN2 = 2, EV_EN3 = 3, EV_TOUT = 4, EV_FDONE = 5, EV_BIN = 6;
    localparam int P_IN_READY = 0, P_OUT_VALID = 1, P_BUSY = 2, P_OUT_INDEX = 3;
    localparam int P_EN = 4, P_FDONE = 5, P_TOUT = 6, P_FD0 = 8;

    typedef struct {
        int kind;
        int cyc;
        int val;
    } ev_t;

    logic clk = 1'b0;
    logic nRESET;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    ev_t  exp_q[$];
    ev_t  probe_q[$];
    logic [2:0] auto_mask = 3'b000;
    logic [2:0] spur = 3'b000;
    logic [2:0] s_en = 3'b000;
    bit   mon_en = 1'b0;
    bit   end_req = 1'b0;
    bit   end_done = 1'b0;
    logic [11:0] fa [8], fb [8], fc [8], fd [8], fe [8], ff [8];

    fft_ctrl_if bus ();

    fft_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .CLK    (clk),
        .nRESET (nRESET),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stage models: done one cycle after the matching enable when enabled in auto_mask, plus injected pulses
    initial begin
        bus.stage1_done = 1'b0;
        bus.stage2_done = 1'b0;
        bus.stage3_done = 1'b0;
        forever begin
            @(negedge clk);
            s_en = {bus.stage3_en, bus.stage2_en, bus.stage1_en};
            @(posedge clk);
            #2;
            {bus.stage3_done, bus.stage2_done, bus.stage1_done} = (s_en & auto_mask) | spur;
        end
    end

    function automatic string pname(input int id);
        case (id)
            P_IN_READY:  return "in_ready";
            P_OUT_VALID: return "out_valid";
            P_BUSY:      return "busy";
            P_OUT_INDEX: return "out_index";
            P_EN:        return "stage_en";
            P_FDONE:     return "frame_done";
            P_TOUT:      return "timeout_err";
            default:     return $sformatf("frame_data[%0d]", id - P_FD0);
        endcase
    endfunction

    function automatic logic [31:0] sample_sig(input int id);
        case (id)
            P_IN_READY:  return {31'd0, bus.in_ready};
            P_OUT_VALID: return {31'd0, bus.out_valid};
            P_BUSY:      return {31'd0, bus.busy};
            P_OUT_INDEX: return {29'd0, bus.out_index};
            P_EN:        return {29'd0, bus.stage3_en, bus.stage2_en, bus.stage1_en};
            P_FDONE:     return {31'd0, bus.frame_done};
            P_TOUT:      return {31'd0, bus.timeout_err};
            default:     return {20'd0, bus.frame_data[3'(id - P_FD0)]};
        endcase
    endfunction

    task automatic got(input int kind, input int val);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL event: actual kind=%0d cyc=%0d val=%0d, required no event", kind, cyc, val);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.val != val) begin
                n_fail++;
                $display("FAIL event: actual kind=%0d cyc=%0d val=%0d, required kind=%0d cyc=%0d val=%0d",
                         kind, cyc, val, e.kind, e.cyc, e.val);
            end
        end
    endtask

    // Monitor: pops expected events as the DUT produces them, and due probes each cycle
    always @(negedge clk) begin
        if (mon_en) begin
            ev_t p;
            logic [31:0] obs;
            if (bus.stage1_en)                  got(EV_EN1, 0);
            if (bus.stage2_en)                  got(EV_EN2, 0);
            if (bus.stage3_en)                  got(EV_EN3, 0);
            if (bus.timeout_err)                got(EV_TOUT, 0);
            if (bus.frame_done)                 got(EV_FDONE, 0);
            if (bus.out_valid && bus.out_ready) got(EV_BIN, int'(bus.out_index));

            n_checks++;
            if ($countones({bus.in_ready, bus.out_valid, bus.stage1_en, bus.stage2_en, bus.stage3_en}) > 1) begin
                n_fail++;
                $display("FAIL exclusive: cyc=%0d actual in_ready/out_valid/en=%b, required at most one high",
                         cyc, {bus.in_ready, bus.out_valid, bus.stage1_en, bus.stage2_en, bus.stage3_en});
            end

            while (probe_q.size() != 0 && probe_q[0].cyc <= cyc) begin
                p   = probe_q.pop_front();
                obs = sample_sig(p.kind);
                n_checks++;
                if (p.cyc != cyc || obs != 32'(p.val)) begin
                    n_fail++;
                    $display("FAIL %s: cyc=%0d actual=0x%0h, required=0x%0h at cyc=%0d",
                             pname(p.kind), cyc, obs, p.val, p.cyc);
                end
            end

            if (end_req && !end_done) begin
                n_checks++;
                if (exp_q.size() != 0) begin
                    n_fail++;
                    $display("FAIL missing_events: actual %0d left, required 0 (next kind=%0d cyc=%0d)",
                             exp_q.size(), exp_q[0].kind, exp_q[0].cyc);
                end
                n_checks++;
                if (probe_q.size() != 0) begin
                    n_fail++;
                    $display("FAIL missing_probes: actual %0d left, required 0", probe_q.size());
                end
                end_done = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input int kind, input int c, input int val);
        exp_q.push_back('{kind, c, val});
    endtask

    task automatic probe(input int id, input int c, input int val);
        probe_q.push_back('{id, c, val});
    endtask

    task automatic probe_frame(input logic [11:0] s [8], input int c);
        for (int i = 0; i < 8; i++) probe(P_FD0 + i, c, int'(s[i]));
    endtask

    // n beats, optionally one idle cycle between beats; returns the cycle of the last beat
    task automatic send(input logic [11:0] s [8], input int n, input bit gap, output int last);
        last = 0;
        for (int k = 0; k < n; k++) begin
            bus.in_valid  = 1'b1;
            bus.in_sample = s[k];
            last          = cyc;
            step();
            bus.in_valid = 1'b0;
            if (gap && k < n - 1) step();
        end
    endtask

    // Full pipeline with every stage answering one cycle after its enable and out_ready held high
    task automatic chain(input int c);
        expect_ev(EV_EN1, c + 1, 0);
        expect_ev(EV_EN2, c + 3, 0);
        expect_ev(EV_EN3, c + 5, 0);
        for (int k = 0; k < 8; k++) expect_ev(EV_BIN, c + 7 + k, k);
        expect_ev(EV_FDONE, c + 15, 0);
    endtask

    initial begin
        int c;
        int p;
        int boff [8];
        logic [3:0] pat;
        boff = '{0, 3, 4, 7, 8, 11, 12, 15};
        pat  = 4'b1001;
        for (int k = 0; k < 8; k++) begin
            fa[k] = 12'(16 * (k + 1));
            fc[k] = 12'(12'h300 - 7 * k);
            fd[k] = 12'(12'hA00 + k);
            fe[k] = 12'(k * k + 5);
            ff[k] = 12'(12'h7F0 - 3 * k);
        end
        fb = '{12'hFFF, 12'h800, 12'h7FF, 12'h001, 12'h123, 12'hABC, 12'h000, 12'h555};

        nRESET        = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sample = '0;
        bus.out_ready = 1'b0;

        // Reset state, then one IDLE cycle before LOAD
        step();
        mon_en = 1'b1;
        probe(P_IN_READY, cyc, 0);
        probe(P_OUT_VALID, cyc, 0);
        probe(P_BUSY, cyc, 0);
        probe(P_OUT_INDEX, cyc, 0);
        probe(P_EN, cyc, 0);
        probe(P_FDONE, cyc, 0);
        probe(P_TOUT, cyc, 0);
        for (int i = 0; i < 8; i++) probe(P_FD0 + i, cyc, 0);
        nRESET = 1'b1;
        probe(P_BUSY, cyc + 1, 1);
        probe(P_IN_READY, cyc + 1, 1);
        step();

        // Back-to-back frame, immediate stage answers, consumer always ready
        bus.out_ready = 1'b1;
        auto_mask     = 3'b111;
        send(fa, 8, 1'b0, c);
        probe_frame(fa, c + 1);
        probe(P_BUSY, c + 5, 1);
        probe(P_OUT_VALID, c + 6, 0);
        probe(P_OUT_VALID, c + 7, 1);
        probe(P_IN_READY, c + 15, 1);
        probe(P_OUT_INDEX, c + 15, 0);
        probe(P_FD0, c + 15, 'h010);
        chain(c);
        repeat (14) step();

        // Consumer stalls with out_ready pattern 1,0,0,1
        bus.out_ready = 1'b0;
        send(fb, 8, 1'b0, c);
        probe_frame(fb, c + 1);
        probe(P_OUT_INDEX, c + 8, 1);
        probe(P_OUT_VALID, c + 9, 1);
        probe(P_OUT_INDEX, c + 9, 1);
        probe(P_IN_READY, c + 23, 1);
        probe(P_OUT_INDEX, c + 23, 0);
        expect_ev(EV_EN1, c + 1, 0);
        expect_ev(EV_EN2, c + 3, 0);
        expect_ev(EV_EN3, c + 5, 0);
        for (int k = 0; k < 8; k++) expect_ev(EV_BIN, c + 7 + boff[k], k);
        expect_ev(EV_FDONE, c + 23, 0);
        while (cyc < c + 23) begin
            bus.out_ready = (cyc >= c + 7) ? pat[2'((cyc - c - 7) % 4)] : 1'b0;
            step();
        end

        // Spurious done pulses in LOAD and S2 are ignored; stage 2 answered late by hand
        bus.out_ready = 1'b1;
        auto_mask     = 3'b101;
        spur          = 3'b100;
        probe(P_IN_READY, cyc + 1, 1);
        probe(P_EN, cyc + 1, 0);
        step();
        spur = 3'b010;
        probe(P_IN_READY, cyc + 1, 1);
        step();
        spur = 3'b000;
        send(fc, 8, 1'b0, c);
        probe_frame(fc, c + 1);
        probe(P_OUT_VALID, c + 5, 0);
        probe(P_IN_READY, c + 5, 0);
        probe(P_BUSY, c + 5, 1);
        expect_ev(EV_EN1, c + 1, 0);
        expect_ev(EV_EN2, c + 3, 0);
        expect_ev(EV_EN3, c + 7, 0);
        for (int k = 0; k < 8; k++) expect_ev(EV_BIN, c + 9 + k, k);
        expect_ev(EV_FDONE, c + 17, 0);
        repeat (3) step();
        spur = 3'b001;
        step();
        spur = 3'b000;
        step();
        spur = 3'b010;
        step();
        spur = 3'b000;
        repeat (10) step();

        // Stage 2 never answers: watchdog abort back to LOAD
        auto_mask = 3'b001;
        send(fd, 8, 1'b0, c);
        expect_ev(EV_EN1, c + 1, 0);
        expect_ev(EV_EN2, c + 3, 0);
        expect_ev(EV_TOUT, c + 3 + TIMEOUT, 0);
        probe(P_BUSY, c + 18, 1);
        probe(P_TOUT, c + 18, 0);
        probe(P_IN_READY, c + 19, 0);
        probe(P_IN_READY, c + 20, 1);
        probe(P_EN, c + 20, 0);
        repeat (19) step();

        // Reset after 5 beats discards the partial frame; next frame (with gaps) needs all 8 beats
        auto_mask = 3'b111;
        send(fe, 5, 1'b0, p);
        nRESET = 1'b0;
        step();
        for (int i = 0; i < 8; i++) probe(P_FD0 + i, cyc, 0);
        probe(P_BUSY, cyc, 0);
        probe(P_IN_READY, cyc, 0);
        probe(P_OUT_VALID, cyc, 0);
        nRESET = 1'b1;
        probe(P_IN_READY, cyc + 1, 1);
        step();
        send(ff, 8, 1'b1, c);
        probe_frame(ff, c + 1);
        chain(c);
        repeat (17) step();

        end_req = 1'b1;
        for (int i = 0; i < 8 && !end_done; i++) step();
        if (!end_done) $display("FAIL end_check: actual not evaluated, required evaluated");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + (end_done ? 0 : 1));
        $finish;
    end
endmodule
